// File: rtl/riscv_nn_hwloop_jump_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_nn_hwloop_jump_ctrl
//
// Purpose:
//   Hardware-loop jump controller. When the instruction in ID sits at the end
//   address of an active hardware loop and retires, the matching loop counter
//   is decremented (one-hot request to the loop register file). If more
//   iterations remain, a jump back to the loop start is requested from the
//   prefetcher one cycle later. The request is held until the prefetcher
//   accepts it, or until a flush or reset drops it.
//
// Handshake (jump request to the prefetcher):
//   hwlp_jump_o is the valid and fetch_ready_i is the ready. The request is
//   transferred in a cycle where both are high. While valid is high and ready
//   is low, hwlp_targ_addr_o is held stable. A flush withdraws valid in the
//   same cycle and drops the request without a transfer.
//
// Ports:
//   clk                - clock, all state changes on its rising edge
//   rst                - synchronous active-high reset
//   current_pc_i       - PC of the instruction in ID
//   id_valid_i         - ID instruction retires this cycle
//   flush_i            - pipeline flush / branch, kills a pending jump
//   hwlp_start_addr_i  - per-loop start addresses
//   hwlp_end_addr_i    - per-loop end addresses (PC of the last instruction)
//   hwlp_counter_i     - per-loop remaining iteration counts
//   fetch_ready_i      - prefetcher accepts the jump target
//   hwlp_dec_cnt_o     - one-hot counter decrement request
//   hwlp_jump_o        - jump request to the prefetcher
//   hwlp_targ_addr_o   - jump target
//   hwlp_jump_cnt_o    - number of accepted loop jumps (0 unless enabled)
//   dbg_state_o        - FSM state (0 = IDLE, 1 = JUMP_PEND)
//
// Configuration:
//   HWLP_JUMP_PERF_CNT_EN - when defined, a saturating 32-bit counter of
//                           accepted jumps drives hwlp_jump_cnt_o. When not
//                           defined, hwlp_jump_cnt_o is tied to 0.
// -----------------------------------------------------------------------------
module riscv_nn_hwloop_jump_ctrl #(
   parameter int N_REGS     = 2,
   parameter int N_REG_BITS = $clog2(N_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              current_pc_i,
   input  logic                     id_valid_i,
   input  logic                     flush_i,
   input  logic [N_REGS-1:0][31:0]  hwlp_start_addr_i,
   input  logic [N_REGS-1:0][31:0]  hwlp_end_addr_i,
   input  logic [N_REGS-1:0][31:0]  hwlp_counter_i,
   input  logic                     fetch_ready_i,
   output logic [N_REGS-1:0]        hwlp_dec_cnt_o,
   output logic                     hwlp_jump_o,
   output logic [31:0]              hwlp_targ_addr_o,
   output logic [31:0]              hwlp_jump_cnt_o,
   output logic                     dbg_state_o
);

   typedef enum logic {
      IDLE      = 1'b0,
      JUMP_PEND = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [31:0]           r_targ;
   logic                  w_load_targ;
   logic                  w_match_any;
   logic [N_REG_BITS-1:0] w_sel_idx;
   logic [N_REGS-1:0]     w_dec_cnt;

   // Priority select: scanning from the highest index down lets the lowest
   // matching index (innermost loop) overwrite any outer match.
   always_comb begin
      w_match_any = 1'b0;
      w_sel_idx   = '0;
      for (int k = N_REGS - 1; k >= 0; k--) begin
         if ((current_pc_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != 32'd0)) begin
            w_match_any = 1'b1;
            w_sel_idx   = N_REG_BITS'(k);
         end
      end
   end

   // Next-state and decrement logic. Reset and flush both force IDLE and
   // suppress the decrement, so a killed instruction never touches a counter.
   always_comb begin
      w_state_nxt = r_state;
      w_dec_cnt   = '0;
      w_load_targ = 1'b0;
      if (rst || flush_i) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (id_valid_i && w_match_any) begin
                  w_dec_cnt[w_sel_idx] = 1'b1;
                  // A count of 1 is the last iteration: decrement, fall through.
                  if (hwlp_counter_i[w_sel_idx] > 32'd1) begin
                     w_state_nxt = JUMP_PEND;
                     w_load_targ = 1'b1;
                  end
               end
            end
            JUMP_PEND: begin
               if (fetch_ready_i) begin
                  w_state_nxt = IDLE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_targ  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_targ) begin
            r_targ <= hwlp_start_addr_i[w_sel_idx];
         end
      end
   end

   // Reset gating keeps the request low even in the cycle rst is first seen
   // while the state register still holds JUMP_PEND.
   assign hwlp_jump_o      = (r_state == JUMP_PEND) && !flush_i && !rst;
   assign hwlp_dec_cnt_o   = w_dec_cnt;
   assign hwlp_targ_addr_o = r_targ;
   assign dbg_state_o      = r_state;

`ifdef HWLP_JUMP_PERF_CNT_EN
   logic [31:0] r_jump_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_jump_cnt <= '0;
      end else if (hwlp_jump_o && fetch_ready_i && (r_jump_cnt != 32'hFFFF_FFFF)) begin
         r_jump_cnt <= r_jump_cnt + 32'd1;
      end
   end

   assign hwlp_jump_cnt_o = r_jump_cnt;
`else
   assign hwlp_jump_cnt_o = '0;
`endif

endmodule
